// File: rtl/seq_divider_if.sv
// Operand/result bundle for the iterative divider.
// The master side presents operands; the slave side (the divider) returns
// the quotient, remainder and status.
interface seq_divider_if #(
    parameter int WS = 32
) ();
    logic          iev;
    logic [WS-1:0] ix;
    logic [WS-1:0] iy;
    logic          ready;
    logic          ov;
    logic [WS-1:0] q;
    logic [WS-1:0] r;
    logic          dz;

    modport master (output iev, ix, iy, input ready, ov, q, r, dz);
    modport slave  (input iev, ix, iy, output ready, ov, q, r, dz);
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// A zero divisor bypasses the iteration and reports all-ones / dividend
// with the dz flag. The embedded property ties every result back to the
// latched operands: q*d + r == n and r < d.
module seq_divider #(
    parameter int WS = 32,
    parameter int WL = 2 * WS
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider_if.slave   bus
);
    localparam int CW = $clog2(WS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg;
    logic [WS-1:0] n_reg;
    logic [WS-1:0] d_reg;
    logic [WS-1:0] acc_reg;
    logic [WS-1:0] quo_reg;
    logic [CW-1:0] count_reg;
    logic [WS-1:0] q_reg;
    logic [WS-1:0] r_reg;
    logic          dz_reg;

    logic [WS:0]   t;
    logic [WS-1:0] acc_next;
    logic [WS-1:0] quo_next;

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    always_comb begin
        t        = {acc_reg, quo_reg[WS-1]} - {1'b0, d_reg};
        acc_next = t[WS] ? {acc_reg[WS-2:0], quo_reg[WS-1]} : t[WS-1:0];
        quo_next = {quo_reg[WS-2:0], ~t[WS]};
    end

    // Control FSM plus datapath registers; results only change on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            d_reg     <= '0;
            acc_reg   <= '0;
            quo_reg   <= '0;
            count_reg <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            dz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.iev) begin
                        n_reg <= bus.ix;
                        d_reg <= bus.iy;
                        if (bus.iy != '0) begin
                            state_reg <= RUN;
                            count_reg <= '0;
                            acc_reg   <= '0;
                            quo_reg   <= bus.ix;
                        end else begin
                            state_reg <= DONE;
                            q_reg     <= '1;
                            r_reg     <= bus.ix;
                            dz_reg    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    quo_reg <= quo_next;
                    if (count_reg == CW'(WS - 1)) begin
                        q_reg     <= quo_next;
                        r_reg     <= acc_next;
                        dz_reg    <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Status decoded purely from the registered state.
    assign bus.ready = (state_reg == IDLE);
    assign bus.ov    = (state_reg == DONE);
    assign bus.q     = q_reg;
    assign bus.r     = r_reg;
    assign bus.dz    = dz_reg;

    // Full-width reconstruction of the dividend from the result.
    logic [WL-1:0] recon;
    assign recon = WL'(q_reg) * WL'(d_reg) + WL'(r_reg);

    // Safety property: a valid result always reconstructs the latched dividend.
    a_div_ok: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.ov && !dz_reg) |-> (recon == WL'(n_reg)) && (r_reg < d_reg));
    a_dz_ok: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.ov && dz_reg) |-> (q_reg == '1) && (r_reg == n_reg));
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, zero divisor, ignored requests
// during RUN, mid-RUN reset, and a back-to-back random burst checked
// against the language's own / and % operators.
module tb_seq_divider;
    localparam int WS = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    seq_divider_if #(.WS(WS)) bus ();

    seq_divider #(.WS(WS), .WL(2 * WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair from IDLE and check the result and its timing.
    // Entered and left at a negedge.
    task automatic do_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int k;
        k = 0;
        while (!bus.ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, " ready"}, 64'(bus.ready), 64'd1);
        bus.iev = 1'b1;
        bus.ix  = x;
        bus.iy  = y;
        @(negedge clk);
        bus.iev = 1'b0;
        bus.ix  = $urandom;
        bus.iy  = $urandom;
        k = 1;
        while (!bus.ov && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 64'(k), edz ? 64'd1 : 64'(WS + 1));
        check({tag, " q"}, 64'(bus.q), 64'(eq));
        check({tag, " r"}, 64'(bus.r), 64'(er));
        check({tag, " dz"}, 64'(bus.dz), 64'(edz));
        $display("div %s: %0d / %0d -> q=%0d r=%0d dz=%0d after %0d cycles",
                 tag, x, y, bus.q, bus.r, bus.dz, k);
        @(negedge clk);
        check({tag, " ov pulse"}, 64'(bus.ov), 64'd0);
        check({tag, " ready after"}, 64'(bus.ready), 64'd1);
    endtask

    logic [31:0] qx[$];
    logic [31:0] qy[$];

    initial begin
        int k;
        int ov_cnt;
        int acc_cnt;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ex;
        logic [31:0] ey;

        n_cmp   = 0;
        n_bad   = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        bus.iev = 1'b0;
        bus.ix  = '0;
        bus.iy  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst ready", 64'(bus.ready), 64'd1);
        check("rst ov", 64'(bus.ov), 64'd0);
        check("rst q", 64'(bus.q), 64'd0);
        check("rst r", 64'(bus.r), 64'd0);
        check("rst dz", 64'(bus.dz), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic division and boundary operands
        do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        do_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        do_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
        do_div("7/100", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
        do_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        do_div("dz clears", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);

        // A request arriving during RUN must be ignored
        bus.iev = 1'b1; bus.ix = 32'd100; bus.iy = 32'd7;
        @(negedge clk);
        bus.iev = 1'b0;
        repeat (5) @(negedge clk);
        check("busy ready", 64'(bus.ready), 64'd0);
        bus.iev = 1'b1; bus.ix = 32'd9; bus.iy = 32'd3;
        @(negedge clk);
        bus.iev = 1'b0;
        k = 0;
        while (!bus.ov && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("busy q", 64'(bus.q), 64'd14);
        check("busy r", 64'(bus.r), 64'd2);
        $display("busy: result q=%0d r=%0d with 9/3 ignored", bus.q, bus.r);
        ov_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ov) ov_cnt++;
        end
        check("busy no 2nd ov", 64'(ov_cnt), 64'd0);
        do_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Reset in the middle of RUN aborts the operation
        bus.iev = 1'b1; bus.ix = 32'd1000; bus.iy = 32'd3;
        @(negedge clk);
        bus.iev = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort ready", 64'(bus.ready), 64'd1);
        check("abort q", 64'(bus.q), 64'd0);
        check("abort r", 64'(bus.r), 64'd0);
        check("abort ov", 64'(bus.ov), 64'd0);
        $display("abort: reset mid-run, ready=%0d q=%0d r=%0d", bus.ready, bus.q, bus.r);
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ov) ov_cnt++;
        end
        check("abort no ov", 64'(ov_cnt), 64'd0);
        do_div("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

        // Back-to-back: iev held high, operands change every cycle
        ov_cnt  = 0;
        acc_cnt = 0;
        bus.iev = 1'b1;
        for (int c = 0; c < 340; c++) begin
            if (bus.ov) begin
                ov_cnt++;
                check("b2b queued", 64'(qx.size() != 0), 64'd1);
                if (qx.size() != 0) begin
                    ex = qx.pop_front();
                    ey = qy.pop_front();
                    if (ey == 0) begin
                        check("b2b dz q", 64'(bus.q), 64'hFFFF_FFFF);
                        check("b2b dz r", 64'(bus.r), 64'(ex));
                        check("b2b dz", 64'(bus.dz), 64'd1);
                    end else begin
                        check("b2b q", 64'(bus.q), 64'(ex / ey));
                        check("b2b r", 64'(bus.r), 64'(ex % ey));
                        check("b2b dz", 64'(bus.dz), 64'd0);
                    end
                    $display("b2b: %0d / %0d -> q=%0d r=%0d dz=%0d", ex, ey, bus.q, bus.r, bus.dz);
                end
            end
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 4) == 0) y = '0;
            bus.ix = x;
            bus.iy = y;
            if (bus.ready) begin
                qx.push_back(x);
                qy.push_back(y);
                acc_cnt++;
            end
            @(negedge clk);
        end
        bus.iev = 1'b0;
        k = 0;
        while (qx.size() != 0 && k < 60) begin
            if (bus.ov) begin
                ov_cnt++;
                ex = qx.pop_front();
                ey = qy.pop_front();
                check("b2b tail q", 64'(bus.q), ey == 0 ? 64'hFFFF_FFFF : 64'(ex / ey));
                check("b2b tail r", 64'(bus.r), ey == 0 ? 64'(ex) : 64'(ex % ey));
                $display("b2b tail: %0d / %0d -> q=%0d r=%0d", ex, ey, bus.q, bus.r);
            end
            @(negedge clk);
            k++;
        end
        check("b2b ov count", 64'(ov_cnt), 64'(acc_cnt));
        check("b2b enough accepts", 64'(acc_cnt >= 5), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
